// File: rtl/bitserial_alu_seq_pkg.sv
// Shared opcode, slice-select and state definitions for the bit-serial ALU sequencer.
package bitserial_alu_seq_pkg;

  localparam logic [3:0] OP_AND   = 4'b0000;
  localparam logic [3:0] OP_OR    = 4'b0001;
  localparam logic [3:0] OP_ADD   = 4'b0010;
  localparam logic [3:0] OP_PASSB = 4'b0011;
  localparam logic [3:0] OP_SUB   = 4'b0110;
  localparam logic [3:0] OP_SLT   = 4'b0111;

  localparam logic [1:0] SEL_AND   = 2'd0;
  localparam logic [1:0] SEL_OR    = 2'd1;
  localparam logic [1:0] SEL_SUM   = 2'd2;
  localparam logic [1:0] SEL_PASSB = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIN  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  function automatic logic op_legal(input logic [3:0] op);
    case (op)
      OP_AND, OP_OR, OP_ADD, OP_PASSB, OP_SUB, OP_SLT: op_legal = 1'b1;
      default:                                         op_legal = 1'b0;
    endcase
  endfunction

  function automatic logic op_binv(input logic [3:0] op);
    op_binv = (op == OP_SUB) || (op == OP_SLT);
  endfunction

  function automatic logic [1:0] op_sel(input logic [3:0] op);
    case (op)
      OP_AND:                 op_sel = SEL_AND;
      OP_OR:                  op_sel = SEL_OR;
      OP_ADD, OP_SUB, OP_SLT: op_sel = SEL_SUM;
      OP_PASSB:               op_sel = SEL_PASSB;
      default:                op_sel = SEL_AND;
    endcase
  endfunction

endpackage

// File: rtl/bitserial_alu_seq_opnd_shift.sv
// Operand and result shift registers plus bit counter for the LSB-first sequencer.
module bitserial_alu_seq_opnd_shift #(
  parameter int WIDTH = 32,
  parameter int CNTW  = $clog2(WIDTH)
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             i_load,
  input  logic             i_shift,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_res_bit,
  output logic             o_a_bit,
  output logic             o_b_bit,
  output logic [WIDTH-1:0] o_result,
  output logic             o_last
);

  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_res;
  logic [CNTW-1:0]  r_cnt;

  logic [WIDTH-1:0] w_a_shr;
  logic [WIDTH-1:0] w_b_shr;
  logic [WIDTH-1:0] w_res_shr;

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH - 1; gi++) begin : g_shr
      assign w_a_shr[gi]   = r_a[gi+1];
      assign w_b_shr[gi]   = r_b[gi+1];
      assign w_res_shr[gi] = r_res[gi+1];
    end
  endgenerate

  // Operands drain toward bit 0; slice results enter at the MSB.
  assign w_a_shr[WIDTH-1]   = 1'b0;
  assign w_b_shr[WIDTH-1]   = 1'b0;
  assign w_res_shr[WIDTH-1] = i_res_bit;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_a   <= '0;
      r_b   <= '0;
      r_res <= '0;
      r_cnt <= '0;
    end else if (i_load) begin
      r_a   <= i_a;
      r_b   <= i_b;
      r_res <= '0;
      r_cnt <= '0;
    end else if (i_shift) begin
      r_a   <= w_a_shr;
      r_b   <= w_b_shr;
      r_res <= w_res_shr;
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_a_bit  = r_a[0];
  assign o_b_bit  = r_b[0];
  assign o_result = r_res;
  assign o_last   = (r_cnt == CNTW'(WIDTH - 1));

endmodule

// File: rtl/bitserial_alu_seq.sv
// Sequences an external 1-bit ALU slice LSB-first across WIDTH cycles and derives result flags.
module bitserial_alu_seq
  import bitserial_alu_seq_pkg::*;
#(
  parameter int WIDTH = 32,
  localparam int CNTW = $clog2(WIDTH)
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             In_Valid,
  output logic             In_Ready,
  input  logic [3:0]       In_Op,
  input  logic [WIDTH-1:0] In_A,
  input  logic [WIDTH-1:0] In_B,
  output logic             Alu_A,
  output logic             Alu_B,
  output logic             Alu_BInv,
  output logic             Alu_CIn,
  output logic [1:0]       Alu_Sel,
  input  logic             Alu_Res,
  input  logic             Alu_COut,
  output logic             Out_Valid,
  input  logic             Out_Ready,
  output logic [WIDTH-1:0] Out_Result,
  output logic             Out_Zero,
  output logic             Out_Ovf,
  output logic             Out_Illegal
);

  state_t           r_state;
  state_t           w_state_next;
  logic [3:0]       r_op;
  logic             r_carry;
  logic             r_cmsb_in;
  logic             r_cmsb_out;
  logic             r_sum_msb;
  logic [WIDTH-1:0] r_result;
  logic             r_zero;
  logic             r_ovf;
  logic             r_illegal;

  logic             w_accept;
  logic             w_shift;
  logic             w_a_bit;
  logic             w_b_bit;
  logic             w_last;
  logic [WIDTH-1:0] w_res_word;
  logic             w_ovf;
  logic             w_slt;
  logic [WIDTH-1:0] w_fin_result;
  logic             w_fin_ovf;

  bitserial_alu_seq_opnd_shift #(
    .WIDTH (WIDTH),
    .CNTW  (CNTW)
  ) u_shift (
    .Clk       (Clk),
    .Reset_n   (Reset_n),
    .i_load    (w_accept),
    .i_shift   (w_shift),
    .i_a       (In_A),
    .i_b       (In_B),
    .i_res_bit (Alu_Res),
    .o_a_bit   (w_a_bit),
    .o_b_bit   (w_b_bit),
    .o_result  (w_res_word),
    .o_last    (w_last)
  );

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_shift      = 1'b0;
    In_Ready     = 1'b0;
    Out_Valid    = 1'b0;
    Alu_A        = 1'b0;
    Alu_B        = 1'b0;
    Alu_BInv     = 1'b0;
    Alu_CIn      = 1'b0;
    Alu_Sel      = SEL_AND;
    case (r_state)
      ST_IDLE: begin
        In_Ready = 1'b1;
        if (In_Valid) begin
          w_accept     = 1'b1;
          // Illegal opcodes skip the serial pass and report straight away.
          w_state_next = op_legal(In_Op) ? ST_RUN : ST_DONE;
        end
      end
      ST_RUN: begin
        w_shift  = 1'b1;
        Alu_A    = w_a_bit;
        Alu_B    = w_b_bit;
        Alu_BInv = op_binv(r_op);
        Alu_CIn  = r_carry;
        Alu_Sel  = op_sel(r_op);
        if (w_last) begin
          w_state_next = ST_FIN;
        end
      end
      ST_FIN: begin
        w_state_next = ST_DONE;
      end
      ST_DONE: begin
        Out_Valid = 1'b1;
        if (Out_Ready) begin
          w_state_next = ST_IDLE;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // Signed overflow is the carry into the MSB differing from the carry out of it.
  always_comb begin
    w_ovf        = r_cmsb_in ^ r_cmsb_out;
    w_slt        = r_sum_msb ^ w_ovf;
    w_fin_result = w_res_word;
    w_fin_ovf    = 1'b0;
    case (r_op)
      OP_ADD, OP_SUB: w_fin_ovf = w_ovf;
      OP_SLT:         w_fin_result = {{(WIDTH-1){1'b0}}, w_slt};
      default:        w_fin_ovf = 1'b0;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_op       <= '0;
      r_carry    <= 1'b0;
      r_cmsb_in  <= 1'b0;
      r_cmsb_out <= 1'b0;
      r_sum_msb  <= 1'b0;
      r_result   <= '0;
      r_zero     <= 1'b0;
      r_ovf      <= 1'b0;
      r_illegal  <= 1'b0;
    end else begin
      if (w_accept) begin
        r_op      <= In_Op;
        r_carry   <= op_binv(In_Op);
        r_illegal <= !op_legal(In_Op);
        if (!op_legal(In_Op)) begin
          r_result <= '0;
          r_zero   <= 1'b1;
          r_ovf    <= 1'b0;
        end
      end
      if (w_shift) begin
        r_carry <= Alu_COut;
        if (w_last) begin
          r_cmsb_in  <= r_carry;
          r_cmsb_out <= Alu_COut;
          r_sum_msb  <= Alu_Res;
        end
      end
      if (r_state == ST_FIN) begin
        r_result <= w_fin_result;
        r_zero   <= (w_fin_result == '0);
        r_ovf    <= w_fin_ovf;
      end
    end
  end

  assign Out_Result  = r_result;
  assign Out_Zero    = r_zero;
  assign Out_Ovf     = r_ovf;
  assign Out_Illegal = r_illegal;

endmodule
